// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types and width helpers for the fifo enqueue arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Owner index width; never narrower than one bit.
    function automatic int calc_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int calc_cnt_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_enq_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin pick: first set request at or above ptr.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W-1:0]      w_ofs;
    logic [ID_W:0]        w_sum;

    // Rotating a doubled copy puts req[ptr] at bit 0 without a modulo mux.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_ofs = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_ofs = ID_W'(k);
            end
        end
    end

    assign any    = |req;
    assign w_sum  = {1'b0, ptr} + {1'b0, w_ofs};
    assign winner = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                                  : w_sum[ID_W-1:0];

endmodule
`default_nettype wire

// File: rtl/fifo_enq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_enq_arbiter
//  Purpose  : Round-robin burst arbiter sharing one fifo enqueue port.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_enq_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = calc_id_w(NUM_REQ),
    parameter int CNT_W      = calc_cnt_w(MAX_BURST)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ID_W-1:0]               owner,
    output logic                          busy,
    output logic                          fifo_enq,
    output logic [DATA_WIDTH-1:0]         fifo_data
);

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  C_LAST_ID  = ID_W'(NUM_REQ - 1);

    arb_state_t            r_state,    w_state_nxt;
    logic [NUM_REQ-1:0]    r_gnt,      w_gnt_nxt;
    logic [ID_W-1:0]       r_owner,    w_owner_nxt;
    logic [ID_W-1:0]       r_rr_ptr,   w_rr_ptr_nxt;
    logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;

    logic                  w_any;
    logic [ID_W-1:0]       w_winner;
    logic                  w_busy;
    logic                  w_beat;
    logic                  w_end;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_rr_ptr),
        .any    (w_any),
        .winner (w_winner)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign w_slice[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_busy = (r_state == ST_BURST);
    assign w_beat = w_busy & req[r_owner] & ~fifo_full;
    // A withdrawn request ends the burst regardless of fifo_full.
    assign w_end  = w_busy & (~req[r_owner] |
                              (w_beat & (last[r_owner] | (r_beat_cnt == C_LAST_CNT))));

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt    = ST_BURST;
                    w_gnt_nxt      = NUM_REQ'(1) << w_winner;
                    w_owner_nxt    = w_winner;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_BURST: begin
                if (w_end) begin
                    w_state_nxt  = ST_IDLE;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = (r_owner == C_LAST_ID) ? '0 : r_owner + ID_W'(1);
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign owner     = r_owner;
    assign busy      = w_busy;
    assign fifo_enq  = w_beat;
    assign fifo_data = w_slice[r_owner];

endmodule
`default_nettype wire

// File: tb/tb_fifo_enq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_enq_arbiter
//  Purpose  : Self-checking bench: vector table, corner sequences, random run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_enq_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 64;
    localparam int MAX_BURST  = 4;

    logic                          clk;
    logic                          reset;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            last;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            gnt;
    logic [1:0]                    owner;
    logic                          busy;
    logic                          fifo_enq;
    logic [DATA_WIDTH-1:0]         fifo_data;

    fifo_enq_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .fifo_enq  (fifo_enq),
        .fifo_data (fifo_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: who holds the port, beats delivered, next search start.
    bit m_valid = 1'b0;
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_beats = 0;
    int m_ptr   = 0;

    logic [3:0] obs_gnt;
    logic       obs_busy;
    logic       obs_enq;
    logic [1:0] obs_owner;

    typedef struct {
        logic       rst;
        logic [3:0] rq;
        logic [3:0] ls;
        logic       fl;
        logic [3:0] gnt;
        logic       busy;
        logic       enq;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_update(input logic rst, input logic [3:0] rq,
                                input logic [3:0] ls, input logic fl);
        bit found;
        bit beat;
        int idx;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_owner = 0;
            m_beats = 0;
            m_ptr   = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (!found && rq[idx]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = idx;
                    m_beats = 0;
                end
            end
        end else begin
            beat = rq[m_owner] && !fl;
            if (beat) m_beats++;
            if (!rq[m_owner] || (beat && (ls[m_owner] || m_beats == MAX_BURST))) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] rq,
                        input logic [3:0] ls, input logic fl);
        logic [3:0] e_gnt;
        logic       e_enq;
        @(negedge clk);
        reset     = rst;
        req       = rq;
        last      = ls;
        fifo_full = fl;
        for (int i = 0; i < NUM_REQ * DATA_WIDTH / 32; i++) data_in[i*32 +: 32] = $urandom;
        #1;
        obs_gnt   = gnt;
        obs_busy  = busy;
        obs_enq   = fifo_enq;
        obs_owner = owner;
        if (m_valid) begin
            e_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            e_enq = m_busy && rq[m_owner] && !fl;
            chk("model_gnt",   obs_gnt,   e_gnt);
            chk("model_busy",  obs_busy,  m_busy);
            chk("model_owner", obs_owner, m_owner[1:0]);
            chk("model_enq",   obs_enq,   e_enq);
            if (e_enq) chk("model_data", fifo_data, data_in[m_owner*DATA_WIDTH +: DATA_WIDTH]);
        end
        @(posedge clk);
        model_update(rst, rq, ls, fl);
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic [3:0] r_req;
        logic [3:0] r_last;
        int         n_enq;

        reset = 1'b1; req = '0; last = '0; fifo_full = 1'b0; data_in = '0;

        // Single producer 2 with last on the 2nd beat, then pointer check.
        tbl[0] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[2] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[3] = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[4] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2};
        tbl[5] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2};
        tbl[6] = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0};
        tbl[7] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0};
        tbl[8] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[9] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};

        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int v = 0; v < 10; v++) begin
            step(tbl[v].rst, tbl[v].rq, tbl[v].ls, tbl[v].fl);
            chk("tbl_gnt",   obs_gnt,   tbl[v].gnt);
            chk("tbl_busy",  obs_busy,  tbl[v].busy);
            chk("tbl_enq",   obs_enq,   tbl[v].enq);
            chk("tbl_owner", obs_owner, tbl[v].owner);
        end

        // All producers requesting: 0,1,2,3,0 with 4 beats each and a bubble.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int b = 0; b < 5; b++) begin
            step(1'b0, 4'b1111, 4'b0000, 1'b0);
            chk("rr_bubble", obs_busy, 1'b0);
            exp_gnt = 4'b0001 << (b % 4);
            for (int j = 0; j < MAX_BURST; j++) begin
                step(1'b0, 4'b1111, 4'b0000, 1'b0);
                chk("rr_gnt", obs_gnt, exp_gnt);
                chk("rr_enq", obs_enq, 1'b1);
            end
        end

        // Owner 1 stalled by fifo_full for 5 cycles mid-burst.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0010, 4'b0000, 1'b0);
        step(1'b0, 4'b0010, 4'b0000, 1'b0);
        chk("full_first_beat", obs_enq, 1'b1);
        n_enq = 1;
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 4'b0010, 4'b0000, 1'b1);
            chk("full_no_enq", obs_enq, 1'b0);
            chk("full_gnt_kept", obs_gnt, 4'b0010);
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 4'b0010, 4'b0000, 1'b0);
            if (obs_enq) n_enq++;
            if (!obs_busy) break;
        end
        chk("full_total_beats", n_enq, 4);
        chk("full_burst_closed", obs_busy, 1'b0);

        // Owner 2 withdraws after one beat; producer 3 is next.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 1'b0);
        step(1'b0, 4'b1100, 4'b0000, 1'b0);
        chk("drop_beat", obs_enq, 1'b1);
        step(1'b0, 4'b1000, 4'b0000, 1'b0);
        chk("drop_busy", obs_busy, 1'b1);
        chk("drop_no_enq", obs_enq, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 1'b0);
        chk("drop_bubble", obs_gnt, 4'b0000);
        step(1'b0, 4'b1000, 4'b0000, 1'b0);
        chk("drop_next_gnt", obs_gnt, 4'b1000);

        // Reset during the 2nd beat aborts the burst and clears the pointer.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        chk("rst_mid_beat2", obs_enq, 1'b1);
        step(1'b0, 4'b1010, 4'b0000, 1'b0);
        chk("rst_gnt", obs_gnt, 4'b0000);
        chk("rst_enq", obs_enq, 1'b0);
        chk("rst_busy", obs_busy, 1'b0);
        step(1'b0, 4'b1010, 4'b0000, 1'b0);
        chk("rst_next_gnt", obs_gnt, 4'b0010);

        // Pointer wraps from 3 to 0.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 1'b0);
        step(1'b0, 4'b1001, 4'b1000, 1'b0);
        chk("wrap_owner3", obs_gnt, 4'b1000);
        step(1'b0, 4'b1001, 4'b0000, 1'b0);
        chk("wrap_bubble", obs_busy, 1'b0);
        step(1'b0, 4'b1001, 4'b0000, 1'b0);
        chk("wrap_gnt0", obs_gnt, 4'b0001);

        // Random traffic with sticky requests.
        r_req = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(7) == 0) r_req[i] = ~r_req[i];
                r_last[i] = ($urandom_range(3) == 0);
            end
            step(($urandom_range(99) == 0), r_req, r_last, ($urandom_range(3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
